mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Request controller between the multi-cycle MIPS datapath and the byte-addressed unified instruction/data memory.
- Turns a CPU req/ready handshake into word-aligned memory strobes (mrd/mwr, inst_data_adr, mem_data_in).
- Adds byte/halfword loads with sign or zero extension.
- Adds byte/halfword stores by read-modify-write, because the memory only writes full 32-bit words.

Parameters:
- LAT_CYCLES, 1, cycles mrd is held before mem_out is captured (1..15).
- ADR_W, 32, address width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  access request, sampled in IDLE
- cpu_we  in  1  1=store, 0=load
- cpu_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- cpu_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- cpu_adr  in  ADR_W  byte address
- cpu_wdata  in  32  store data, right-justified for byte/half
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  32  load result, held until next completed load
- cpu_misalign  out  1  valid with cpu_ready; access was suppressed
- inst_data_adr  out  ADR_W  word-aligned memory address, {adr[ADR_W-1:2],2'b00}
- mem_data_in  out  32  memory write data
- mrd  out  1  memory read enable
- mwr  out  1  memory write enable, sampled by memory on posedge
- mem_out  in  32  memory read data (combinational from memory)

Behaviour:
- Reset: state IDLE; all outputs 0; latched request cleared; lane-counter 0.
- Byte lanes are little-endian. Byte offset k = adr[1:0] occupies mem word bits [8k+7:8k]. Half offset adr[1] occupies bits [16*adr[1]+15:16*adr[1]].
- IDLE:
  - cpu_req=1 at a posedge latches adr, wdata, size, we, unsigned.
  - Misaligned requests (half with adr[0]=1; word with adr[1:0]!=0) go directly to DONE with cpu_misalign=1. No mrd/mwr is asserted.
  - Otherwise: loads -> RD; word stores -> WR; byte/half stores -> RMW_RD.
- RD: mrd=1 and inst_data_adr driven for exactly LAT_CYCLES cycles. On the last cycle, capture mem_out, extract the lane, extend to 32 bits into cpu_rdata, then go to DONE.
- WR: mwr=1 for exactly one cycle with mem_data_in=wdata, then DONE.
- RMW_RD: identical to RD, but the captured word goes to an internal register and cpu_rdata is unchanged. Then RMW_WR.
- RMW_WR: mwr=1 for one cycle. mem_data_in = captured word with only the target lane replaced by wdata[7:0] or wdata[15:0]. Then DONE.
- DONE: cpu_ready=1 for one cycle; cpu_misalign is valid in that cycle only; then IDLE.
- cpu_req is ignored outside IDLE. A request still high in the cycle after DONE is accepted as a new access.
- Latency from the accepting edge to cpu_ready:
  - load: LAT_CYCLES+1
  - word store: 2
  - sub-word store: LAT_CYCLES+2
  - misaligned: 1
- mrd and mwr are never high together. Both are registered outputs (no combinational path from cpu_req).
- Reset mid-operation: returns to IDLE immediately and drops mrd/mwr asynchronously. No partial RMW write may reach memory after reset deassertion.
- Stores never modify cpu_rdata.

Optional Feature:
- Macro MEM_ACCESS_STATS_EN.
- Defined: adds outputs stat_rd[15:0], stat_wr[15:0] and stat_misalign[15:0].
  - stat_rd counts completed loads and stat_wr counts completed stores, each at the cycle cpu_ready=1.
  - stat_misalign counts suppressed misaligned accesses.
  - Counters wrap at 16'hFFFF -> 0 and are cleared by rst.
  - An RMW store counts as 1 write, not as a read.
- Not defined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Word round trip (LAT_CYCLES=1): store 32'hDEADBEEF at 2000, then load word at 2000 -> cpu_rdata=32'hDEADBEEF; store ready 2 cycles after accept; load ready 2 cycles after accept; mwr high exactly 1 cycle.
- Sub-word store RMW: mem[2000..2003] word = 32'h11223344; byte store 8'hAA at 2002 -> word becomes 32'h11AA3344. Half store 16'h5566 at 2000 -> 32'h11AA5566. Confirm mrd then mwr, never overlapping.
- Extension: word 32'h80FF7F01 at 1000. Signed byte at 1002 -> 32'hFFFFFFFF. Unsigned byte at 1002 -> 32'h000000FF. Signed half at 1002 -> 32'hFFFF80FF. Signed byte at 1000 -> 32'h00000001.
- Misalign: word load at 1001 and half store at 1003 -> cpu_ready 1 cycle after accept with cpu_misalign=1; mrd/mwr stay 0; memory unchanged.
- Latency sweep LAT_CYCLES=3: load at 1000 -> mrd high exactly 3 cycles; cpu_ready 4 cycles after accept. Holding cpu_req high issues back-to-back accesses with one idle cycle between ready and the next mrd.
- Reset mid-RMW: assert rst during RMW_RD of a byte store to 2004 -> mrd/mwr drop at once; word at 2004 unchanged; all outputs 0. With MEM_ACCESS_STATS_EN the counters read 0.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side request controller for a byte-addressed unified memory
// that only reads and writes full 32-bit words.
//
// Purpose:
//   Turns a cpu_req/cpu_ready handshake into word-aligned mrd/mwr strobes.
//   Byte/half loads are extracted from the read word and sign/zero extended.
//   Byte/half stores are done as read-modify-write.
//   Misaligned accesses are suppressed and flagged on cpu_misalign.
//
// Parameters:
//   LAT_CYCLES  cycles mrd is held before mem_out is captured (1..15)
//   ADR_W       address width
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cpu_req/we/size     request, 1=store, 00 byte/01 half/1x word
//   cpu_unsigned        loads: 1 zero-extend, 0 sign-extend
//   cpu_adr, cpu_wdata  byte address, right-justified store data
//   cpu_ready           one-cycle completion pulse
//   cpu_rdata           load result, held until the next completed load
//   cpu_misalign        valid with cpu_ready; access was suppressed
//   inst_data_adr       word-aligned memory address
//   mem_data_in         memory write data
//   mrd, mwr            memory read / write enables (registered)
//   mem_out             memory read data
//
// Optional build macro MEM_ACCESS_STATS_EN adds stat_rd, stat_wr and
// stat_misalign 16-bit wrapping counters.

module mem_access_ctrl #(
   parameter int LAT_CYCLES = 1,
   parameter int ADR_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [1:0]       cpu_size,
   input  logic             cpu_unsigned,
   input  logic [ADR_W-1:0] cpu_adr,
   input  logic [31:0]      cpu_wdata,
   output logic             cpu_ready,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_misalign,
   output logic [ADR_W-1:0] inst_data_adr,
   output logic [31:0]      mem_data_in,
   output logic             mrd,
   output logic             mwr,
   input  logic [31:0]      mem_out
`ifdef MEM_ACCESS_STATS_EN
   ,
   output logic [15:0]      stat_rd,
   output logic [15:0]      stat_wr,
   output logic [15:0]      stat_misalign
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_WR,
      S_RMW_RD,
      S_RMW_WR,
      S_DONE
   } state_t;

   localparam logic [3:0] LAT_LAST = 4'(LAT_CYCLES - 1);

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [1:0]  r_off;
   logic [1:0]  r_size;
   logic        r_uns;
   logic [15:0] r_wdata;
`ifdef MEM_ACCESS_STATS_EN
   logic        r_we;
`endif

   logic        w_misal;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ext;
   logic [31:0] w_merge;

   assign w_misal = ((cpu_size == 2'b01) && cpu_adr[0]) ||
                    (cpu_size[1] && (cpu_adr[1:0] != 2'b00));

   // Lane extraction and lane merge both work on the live mem_out word
   // in the final read cycle.
   always_comb begin
      w_byte  = mem_out[{r_off, 3'b000} +: 8];
      w_half  = mem_out[{r_off[1], 4'b0000} +: 16];
      w_ext   = mem_out;
      w_merge = mem_out;
      unique case (r_size)
         2'b00: begin
            w_ext = r_uns ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
            w_merge[{r_off, 3'b000} +: 8] = r_wdata[7:0];
         end
         2'b01: begin
            w_ext = r_uns ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
            w_merge[{r_off[1], 4'b0000} +: 16] = r_wdata;
         end
         default: begin
            w_ext   = mem_out;
            w_merge = mem_out;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_cnt         <= 4'd0;
         r_off         <= 2'b00;
         r_size        <= 2'b00;
         r_uns         <= 1'b0;
         r_wdata       <= 16'h0;
         cpu_ready     <= 1'b0;
         cpu_rdata     <= 32'h0;
         cpu_misalign  <= 1'b0;
         inst_data_adr <= '0;
         mem_data_in   <= 32'h0;
         mrd           <= 1'b0;
         mwr           <= 1'b0;
`ifdef MEM_ACCESS_STATS_EN
         r_we          <= 1'b0;
         stat_rd       <= 16'h0;
         stat_wr       <= 16'h0;
         stat_misalign <= 16'h0;
`endif
      end else begin
         cpu_ready    <= 1'b0;
         cpu_misalign <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (cpu_req) begin
                  r_off         <= cpu_adr[1:0];
                  r_size        <= cpu_size;
                  r_uns         <= cpu_unsigned;
                  r_wdata       <= cpu_wdata[15:0];
                  r_cnt         <= 4'd0;
                  inst_data_adr <= {cpu_adr[ADR_W-1:2], 2'b00};
`ifdef MEM_ACCESS_STATS_EN
                  r_we          <= cpu_we;
`endif
                  if (w_misal) begin
                     r_state      <= S_DONE;
                     cpu_ready    <= 1'b1;
                     cpu_misalign <= 1'b1;
                  end else if (!cpu_we) begin
                     r_state <= S_RD;
                     mrd     <= 1'b1;
                  end else if (cpu_size[1]) begin
                     r_state     <= S_WR;
                     mwr         <= 1'b1;
                     mem_data_in <= cpu_wdata;
                  end else begin
                     r_state <= S_RMW_RD;
                     mrd     <= 1'b1;
                  end
               end
            end
            S_RD, S_RMW_RD: begin
               if (r_cnt == LAT_LAST) begin
                  mrd <= 1'b0;
                  if (r_state == S_RD) begin
                     cpu_rdata <= w_ext;
                     cpu_ready <= 1'b1;
                     r_state   <= S_DONE;
                  end else begin
                     mem_data_in <= w_merge;
                     mwr         <= 1'b1;
                     r_state     <= S_RMW_WR;
                  end
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            S_WR, S_RMW_WR: begin
               mwr       <= 1'b0;
               cpu_ready <= 1'b1;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               r_state <= S_IDLE;
`ifdef MEM_ACCESS_STATS_EN
               if (cpu_misalign)
                  stat_misalign <= stat_misalign + 16'd1;
               else if (r_we)
                  stat_wr <= stat_wr + 16'd1;
               else
                  stat_rd <= stat_rd + 16'd1;
`endif
            end
            default: begin
               r_state <= S_IDLE;
               mrd     <= 1'b0;
               mwr     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed bench for mem_access_ctrl, two instances
// (LAT_CYCLES=1 and 3) sharing stimulus, each with its own word memory.

module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, we, uns;
   logic [1:0]  size;
   logic [31:0] adr, wdata;

   logic        rdy1, mis1, mrd1, mwr1;
   logic [31:0] rd1, ia1, md1, mo1;
   logic        rdy3, mis3, mrd3, mwr3;
   logic [31:0] rd3, ia3, md3, mo3;

   logic [31:0] m1 [0:1023];
   logic [31:0] m3 [0:1023];
   logic        pl_en;
   logic [9:0]  pl_idx;
   logic [31:0] pl_dat;

   int errors = 0;
   int checks = 0;
   int l1, l3, nr1, nr3, nw1, nw3;
   logic ov, ms1, ms3;

   always #5 clk = ~clk;

   mem_access_ctrl #(.LAT_CYCLES(1), .ADR_W(32)) dut1 (
      .clk(clk), .rst(rst), .cpu_req(req), .cpu_we(we),
      .cpu_size(size), .cpu_unsigned(uns), .cpu_adr(adr),
      .cpu_wdata(wdata), .cpu_ready(rdy1), .cpu_rdata(rd1),
      .cpu_misalign(mis1), .inst_data_adr(ia1), .mem_data_in(md1),
      .mrd(mrd1), .mwr(mwr1), .mem_out(mo1)
   );

   mem_access_ctrl #(.LAT_CYCLES(3), .ADR_W(32)) dut3 (
      .clk(clk), .rst(rst), .cpu_req(req), .cpu_we(we),
      .cpu_size(size), .cpu_unsigned(uns), .cpu_adr(adr),
      .cpu_wdata(wdata), .cpu_ready(rdy3), .cpu_rdata(rd3),
      .cpu_misalign(mis3), .inst_data_adr(ia3), .mem_data_in(md3),
      .mrd(mrd3), .mwr(mwr3), .mem_out(mo3)
   );

   assign mo1 = m1[ia1[11:2]];
   assign mo3 = m3[ia3[11:2]];

   always @(posedge clk) begin
      if (mwr1) m1[ia1[11:2]] <= md1;
      else if (pl_en) m1[pl_idx] <= pl_dat;
      if (mwr3) m3[ia3[11:2]] <= md3;
      else if (pl_en) m3[pl_idx] <= pl_dat;
   end

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      pl_en = 1'b1; pl_idx = a[11:2]; pl_dat = d;
      @(negedge clk);
      pl_en = 1'b0;
   endtask

   task automatic access(input logic w, input logic [1:0] s,
                         input logic u, input logic [31:0] a,
                         input logic [31:0] d);
      @(negedge clk);
      we = w; size = s; uns = u; adr = a; wdata = d; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      l1 = 0; l3 = 0; nr1 = 0; nr3 = 0; nw1 = 0; nw3 = 0;
      ov = 1'b0; ms1 = 1'b0; ms3 = 1'b0;
      for (int n = 1; n <= 40 && (l1 == 0 || l3 == 0); n++) begin
         @(negedge clk);
         if (mrd1) nr1++;
         if (mrd3) nr3++;
         if (mwr1) nw1++;
         if (mwr3) nw3++;
         if ((mrd1 && mwr1) || (mrd3 && mwr3)) ov = 1'b1;
         if (rdy1 && l1 == 0) begin l1 = n; ms1 = mis1; end
         if (rdy3 && l3 == 0) begin l3 = n; ms3 = mis3; end
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1; req = 1'b0; we = 1'b0; uns = 1'b0;
      size = 2'b00; adr = 32'h0; wdata = 32'h0; pl_en = 1'b0;
      pl_idx = 10'h0; pl_dat = 32'h0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rdy1, mis1, mrd1, mwr1, rdy3, mis3, mrd3, mwr3} !== 8'h0) begin
         errors++;
         $display("FAIL reset_ctl: got %b required 0",
                  {rdy1, mis1, mrd1, mwr1, rdy3, mis3, mrd3, mwr3});
      end
      checks++;
      if ({rd1, ia1, md1} !== 96'h0) begin
         errors++;
         $display("FAIL reset_data: got %h %h %h required 0", rd1, ia1, md1);
      end
      rst = 1'b0;
   endtask

   task automatic test_word_rt;
      access(1'b1, 2'b10, 1'b0, 32'd2000, 32'hDEADBEEF);
      checks++;
      if (l1 != 2 || l3 != 2) begin
         errors++;
         $display("FAIL wst_lat: got %0d/%0d required 2/2", l1, l3);
      end
      checks++;
      if (nw1 != 1 || nw3 != 1 || nr1 != 0 || nr3 != 0) begin
         errors++;
         $display("FAIL wst_strobes: got mwr %0d/%0d mrd %0d/%0d required 1/1 0/0",
                  nw1, nw3, nr1, nr3);
      end
      checks++;
      if (m1[500] !== 32'hDEADBEEF || m3[500] !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wst_mem: got %h/%h required deadbeef", m1[500], m3[500]);
      end
      access(1'b0, 2'b10, 1'b0, 32'd2000, 32'h0);
      checks++;
      if (rd1 !== 32'hDEADBEEF || rd3 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL wld_data: got %h/%h required deadbeef", rd1, rd3);
      end
      checks++;
      if (l1 != 2 || l3 != 4) begin
         errors++;
         $display("FAIL wld_lat: got %0d/%0d required 2/4", l1, l3);
      end
      checks++;
      if (nr1 != 1 || nr3 != 3 || nw1 != 0 || nw3 != 0) begin
         errors++;
         $display("FAIL wld_strobes: got mrd %0d/%0d mwr %0d/%0d required 1/3 0/0",
                  nr1, nr3, nw1, nw3);
      end
   endtask

   task automatic test_rmw;
      preload(32'd2000, 32'h11223344);
      access(1'b1, 2'b00, 1'b0, 32'd2002, 32'h000000AA);
      checks++;
      if (m1[500] !== 32'h11AA3344 || m3[500] !== 32'h11AA3344) begin
         errors++;
         $display("FAIL rmw_byte: got %h/%h required 11aa3344", m1[500], m3[500]);
      end
      checks++;
      if (l1 != 3 || l3 != 5) begin
         errors++;
         $display("FAIL rmw_lat: got %0d/%0d required 3/5", l1, l3);
      end
      checks++;
      if (ov || nr1 != 1 || nr3 != 3 || nw1 != 1 || nw3 != 1) begin
         errors++;
         $display("FAIL rmw_strobes: got ov %b mrd %0d/%0d mwr %0d/%0d required 0 1/3 1/1",
                  ov, nr1, nr3, nw1, nw3);
      end
      access(1'b1, 2'b01, 1'b0, 32'd2000, 32'hFFFF5566);
      checks++;
      if (m1[500] !== 32'h11AA5566 || m3[500] !== 32'h11AA5566) begin
         errors++;
         $display("FAIL rmw_half: got %h/%h required 11aa5566", m1[500], m3[500]);
      end
      checks++;
      if (ov) begin
         errors++;
         $display("FAIL rmw_overlap: got %b required 0", ov);
      end
      checks++;
      if (rd1 !== 32'hDEADBEEF || rd3 !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL st_keeps_rdata: got %h/%h required deadbeef", rd1, rd3);
      end
   endtask

   task automatic test_ext;
      logic [1:0]  sz [4] = '{2'b00, 2'b00, 2'b01, 2'b00};
      logic        un [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [31:0] ad [4] = '{32'd1002, 32'd1002, 32'd1002, 32'd1000};
      logic [31:0] ex [4] = '{32'hFFFFFFFF, 32'h000000FF,
                              32'hFFFF80FF, 32'h00000001};
      preload(32'd1000, 32'h80FF7F01);
      for (int i = 0; i < 4; i++) begin
         access(1'b0, sz[i], un[i], ad[i], 32'h0);
         checks++;
         if (rd1 !== ex[i] || rd3 !== ex[i]) begin
            errors++;
            $display("FAIL ext_%0d: got %h/%h required %h", i, rd1, rd3, ex[i]);
         end
      end
   endtask

   task automatic test_misalign;
      access(1'b0, 2'b10, 1'b0, 32'd1001, 32'h0);
      checks++;
      if (l1 != 1 || l3 != 1 || !ms1 || !ms3) begin
         errors++;
         $display("FAIL mis_ld: got lat %0d/%0d mis %b/%b required 1/1 1/1",
                  l1, l3, ms1, ms3);
      end
      checks++;
      if (nr1 + nr3 + nw1 + nw3 != 0) begin
         errors++;
         $display("FAIL mis_ld_strobes: got %0d required 0", nr1 + nr3 + nw1 + nw3);
      end
      access(1'b1, 2'b01, 1'b0, 32'd1003, 32'h0000BEEF);
      checks++;
      if (l1 != 1 || l3 != 1 || !ms1 || !ms3) begin
         errors++;
         $display("FAIL mis_st: got lat %0d/%0d mis %b/%b required 1/1 1/1",
                  l1, l3, ms1, ms3);
      end
      checks++;
      if (nr1 + nr3 + nw1 + nw3 != 0 || m1[250] !== 32'h80FF7F01 ||
          m3[250] !== 32'h80FF7F01) begin
         errors++;
         $display("FAIL mis_st_mem: got strobes %0d mem %h/%h required 0 80ff7f01",
                  nr1 + nr3 + nw1 + nw3, m1[250], m3[250]);
      end
      access(1'b0, 2'b10, 1'b0, 32'd1000, 32'h0);
      checks++;
      if (ms1 || ms3) begin
         errors++;
         $display("FAIL aligned_no_mis: got %b/%b required 0/0", ms1, ms3);
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] t_mrd1, t_rdy1, t_mrd3, t_rdy3;
      t_mrd1 = '0; t_rdy1 = '0; t_mrd3 = '0; t_rdy3 = '0;
      @(negedge clk);
      we = 1'b0; size = 2'b10; uns = 1'b0; adr = 32'd1000; req = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         t_mrd1 = {t_mrd1[8:0], mrd1};
         t_rdy1 = {t_rdy1[8:0], rdy1};
         t_mrd3 = {t_mrd3[8:0], mrd3};
         t_rdy3 = {t_rdy3[8:0], rdy3};
      end
      req = 1'b0;
      checks++;
      if (t_mrd3 !== 10'b1110011100 || t_rdy3 !== 10'b0001000010) begin
         errors++;
         $display("FAIL b2b_lat3: got mrd %b rdy %b required 1110011100 0001000010",
                  t_mrd3, t_rdy3);
      end
      checks++;
      if (t_mrd1 !== 10'b1001001001 || t_rdy1 !== 10'b0100100100) begin
         errors++;
         $display("FAIL b2b_lat1: got mrd %b rdy %b required 1001001001 0100100100",
                  t_mrd1, t_rdy1);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (rd3 !== 32'h80FF7F01) begin
         errors++;
         $display("FAIL b2b_data: got %h required 80ff7f01", rd3);
      end
   endtask

   task automatic test_reset_mid;
      preload(32'd2004, 32'h01020304);
      @(negedge clk);
      we = 1'b1; size = 2'b00; uns = 1'b0; adr = 32'd2004;
      wdata = 32'h000000AA; req = 1'b1;
      @(posedge clk);
      #1 req = 1'b0;
      @(negedge clk);
      checks++;
      if (!mrd1 || !mrd3) begin
         errors++;
         $display("FAIL rmw_rd_active: got %b/%b required 1/1", mrd1, mrd3);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({mrd1, mwr1, mrd3, mwr3} !== 4'h0) begin
         errors++;
         $display("FAIL rst_async: got %b required 0000", {mrd1, mwr1, mrd3, mwr3});
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (m1[501] !== 32'h01020304 || m3[501] !== 32'h01020304) begin
         errors++;
         $display("FAIL rst_mem: got %h/%h required 01020304", m1[501], m3[501]);
      end
      checks++;
      if ({rdy1, mis1, mrd1, mwr1, rdy3, mis3, mrd3, mwr3} !== 8'h0 ||
          {rd1, ia1, md1, rd3, ia3, md3} !== 192'h0) begin
         errors++;
         $display("FAIL rst_outputs: got ctl %b data %h %h %h required 0",
                  {rdy1, mis1, mrd1, mwr1, rdy3, mis3, mrd3, mwr3}, rd1, ia1, md1);
      end
   endtask

   initial begin
      test_reset();
      test_word_rt();
      test_rmw();
      test_ext();
      test_misalign();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
